// File: rtl/obi_amo_sbr.sv
// OBI subordinate in front of a 1-cycle single-port word SRAM; plain reads/writes plus atomic RMW AMOs.
// Optional LR/SC reservation support is built when OBI_AMO_LRSC_EN is defined.
module obi_amo_sbr #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IdWidth   = 1,
  parameter int unsigned NumWords  = 256,
  parameter bit          UseRReady = 1'b0
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         req_i,
  output logic                         gnt_o,
  input  logic [AddrWidth-1:0]         addr_i,
  input  logic                         we_i,
  input  logic [3:0]                   be_i,
  input  logic [DataWidth-1:0]         wdata_i,
  input  logic [IdWidth-1:0]           aid_i,
  input  logic [5:0]                   atop_i,
  output logic                         rvalid_o,
  input  logic                         rready_i,
  output logic [DataWidth-1:0]         rdata_o,
  output logic [IdWidth-1:0]           rid_o,
  output logic                         err_o,
  output logic                         exokay_o,
  output logic                         mem_req_o,
  output logic                         mem_we_o,
  output logic [$clog2(NumWords)-1:0]  mem_addr_o,
  output logic [3:0]                   mem_be_o,
  output logic [DataWidth-1:0]         mem_wdata_o,
  input  logic [DataWidth-1:0]         mem_rdata_i
);

  localparam int unsigned IdxWidth      = $clog2(NumWords);
  localparam int unsigned WordAddrWidth = AddrWidth - 2;

  localparam logic [5:0] ATOPNONE = 6'h00;
  localparam logic [5:0] AMOADD   = 6'h20;
  localparam logic [5:0] AMOSWAP  = 6'h21;
  localparam logic [5:0] AMOXOR   = 6'h24;
  localparam logic [5:0] AMOOR    = 6'h28;
  localparam logic [5:0] AMOAND   = 6'h2C;
  localparam logic [5:0] AMOMIN   = 6'h30;
  localparam logic [5:0] AMOMAX   = 6'h34;
  localparam logic [5:0] AMOMINU  = 6'h38;
  localparam logic [5:0] AMOMAXU  = 6'h3C;

  if (DataWidth != 32) begin : g_dw_check
    $fatal(1, "obi_amo_sbr: DataWidth must be 32");
  end
  if (NumWords < 2) begin : g_nw_check
    $fatal(1, "obi_amo_sbr: NumWords must be >= 2");
  end

  typedef enum logic [1:0] {IDLE, ACC, AMO_WR, RESP} state_e;

  state_e state_q, state_d, start_state;

  logic [WordAddrWidth-1:0] word_addr;
  logic [IdxWidth-1:0]      idx;
  logic oob, is_none, is_amo, is_lr, is_sc, sc_ok, atop_ok, req_err;
  logic rready_eff, accept;

  logic [IdxWidth-1:0]  q_idx;
  logic [IdWidth-1:0]   q_id;
  logic [3:0]           q_be;
  logic [DataWidth-1:0] q_wdata;
  logic [5:0]           q_atop;
  logic q_err, q_rd_mem, q_sc_fail, q_exok;

  logic [DataWidth-1:0] rdata_q;
  logic [IdWidth-1:0]   rid_q;
  logic                 err_q, exok_q;
  logic [DataWidth-1:0] amo_result;

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^addr_i[1:0];

  // Request decode; out-of-range uses the full word address, not just the SRAM index bits.
  assign word_addr = addr_i[AddrWidth-1:2];
  assign idx       = word_addr[IdxWidth-1:0];
  assign oob       = (word_addr >= WordAddrWidth'(NumWords));
  assign is_none   = (atop_i == ATOPNONE);
  assign is_amo    = atop_i inside {AMOSWAP, AMOADD, AMOXOR, AMOAND, AMOOR,
                                    AMOMIN, AMOMAX, AMOMINU, AMOMAXU};
  assign atop_ok   = is_none | is_amo | is_lr | is_sc;
  assign req_err   = oob | ~atop_ok | (~is_none & ~we_i) | (we_i & (be_i == 4'h0));

  assign rready_eff  = rready_i | ~UseRReady;
  assign gnt_o       = rst_ni & ((state_q == IDLE) | ((state_q == RESP) & rready_eff));
  assign accept      = req_i & gnt_o;
  assign start_state = (is_amo & ~req_err) ? AMO_WR : ACC;
  assign rvalid_o    = (state_q == RESP);
  assign rdata_o     = rdata_q;
  assign rid_o       = rid_q;
  assign err_o       = err_q;
  assign exokay_o    = exok_q;

`ifdef OBI_AMO_LRSC_EN
  localparam logic [5:0] ATOPLR = 6'h22;
  localparam logic [5:0] ATOPSC = 6'h23;

  logic                resv_valid_q;
  logic [IdxWidth-1:0] resv_idx_q;

  assign is_lr = (atop_i == ATOPLR);
  assign is_sc = (atop_i == ATOPSC);
  assign sc_ok = is_sc & resv_valid_q & (resv_idx_q == idx);

  // Reservation: set by LR, consumed by any SC, killed by writes/AMOs to the reserved word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resv_valid_q <= 1'b0;
      resv_idx_q   <= '0;
    end else if (accept && !req_err) begin
      if (is_lr) begin
        resv_valid_q <= 1'b1;
        resv_idx_q   <= idx;
      end else if (is_sc) begin
        resv_valid_q <= 1'b0;
      end else if (we_i && (idx == resv_idx_q)) begin
        resv_valid_q <= 1'b0;
      end
    end
  end
`else
  assign is_lr = 1'b0;
  assign is_sc = 1'b0;
  assign sc_ok = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        if (accept) state_d = start_state;
      ACC, AMO_WR: state_d = RESP;
      RESP:        if (rready_eff) state_d = req_i ? start_state : IDLE;
      default:     state_d = IDLE;
    endcase
  end

  // Transaction context captured on grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_idx     <= '0;
      q_id      <= '0;
      q_be      <= 4'h0;
      q_wdata   <= '0;
      q_atop    <= ATOPNONE;
      q_err     <= 1'b0;
      q_rd_mem  <= 1'b0;
      q_sc_fail <= 1'b0;
      q_exok    <= 1'b0;
    end else if (accept) begin
      q_idx     <= idx;
      q_id      <= aid_i;
      q_be      <= be_i;
      q_wdata   <= wdata_i;
      q_atop    <= atop_i;
      q_err     <= req_err;
      q_rd_mem  <= ~req_err & (~we_i | is_lr);
      q_sc_fail <= ~req_err & is_sc & ~sc_ok;
      q_exok    <= ~req_err & (is_lr | sc_ok);
    end
  end

  always_comb begin
    amo_result = q_wdata;
    case (q_atop)
      AMOADD:  amo_result = mem_rdata_i + q_wdata;
      AMOXOR:  amo_result = mem_rdata_i ^ q_wdata;
      AMOAND:  amo_result = mem_rdata_i & q_wdata;
      AMOOR:   amo_result = mem_rdata_i | q_wdata;
      AMOMIN:  amo_result = ($signed(mem_rdata_i) < $signed(q_wdata)) ? mem_rdata_i : q_wdata;
      AMOMAX:  amo_result = ($signed(mem_rdata_i) > $signed(q_wdata)) ? mem_rdata_i : q_wdata;
      AMOMINU: amo_result = (mem_rdata_i < q_wdata) ? mem_rdata_i : q_wdata;
      AMOMAXU: amo_result = (mem_rdata_i > q_wdata) ? mem_rdata_i : q_wdata;
      default: amo_result = q_wdata;
    endcase
  end

  // SRAM port: request on the grant cycle, plus the AMO write-back in AMO_WR.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = idx;
    mem_be_o    = 4'hF;
    mem_wdata_o = wdata_i;
    if (state_q == AMO_WR) begin
      mem_req_o   = 1'b1;
      mem_we_o    = 1'b1;
      mem_addr_o  = q_idx;
      mem_be_o    = q_be;
      mem_wdata_o = amo_result;
    end else if (accept && !req_err) begin
      if (is_amo || is_lr) begin
        mem_req_o = 1'b1;
      end else if (is_sc) begin
        mem_req_o = sc_ok;
        mem_we_o  = 1'b1;
        mem_be_o  = be_i;
      end else begin
        mem_req_o = 1'b1;
        mem_we_o  = we_i;
        mem_be_o  = be_i;
      end
    end
  end

  // Response registers, loaded one cycle after the grant and held through RESP.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
      rid_q   <= '0;
      err_q   <= 1'b0;
      exok_q  <= 1'b0;
    end else if (state_q == ACC) begin
      rdata_q <= q_rd_mem ? mem_rdata_i : DataWidth'(q_sc_fail);
      rid_q   <= q_id;
      err_q   <= q_err;
      exok_q  <= q_exok;
    end else if (state_q == AMO_WR) begin
      rdata_q <= mem_rdata_i;
      rid_q   <= q_id;
      err_q   <= 1'b0;
      exok_q  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_obi_amo_sbr.sv
// Scoreboard bench for obi_amo_sbr: directed requests push expected responses, a monitor checks them.
module tb_obi_amo_sbr;

  localparam int unsigned NW = 256;
  localparam logic [5:0] NONE = 6'h00;
  localparam logic [5:0] ADD  = 6'h20;
  localparam logic [5:0] LR   = 6'h22;
  localparam logic [5:0] SC   = 6'h23;
  localparam logic [5:0] MIN  = 6'h30;
  localparam logic [5:0] MAXU = 6'h3C;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req, gnt, we, rvalid, rready, err, exokay;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  be;
  logic [0:0]  aid, rid;
  logic [5:0]  atop;
  logic        mem_req, mem_we;
  logic [7:0]  mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  obi_amo_sbr #(
    .AddrWidth(32), .DataWidth(32), .IdWidth(1), .NumWords(NW), .UseRReady(1'b1)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .aid_i(aid), .atop_i(atop), .rvalid_o(rvalid),
    .rready_i(rready), .rdata_o(rdata), .rid_o(rid), .err_o(err), .exokay_o(exokay),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_be_o(mem_be),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  // SRAM model with 1-cycle read latency
  logic [31:0] mem_m [NW];
  int memreq_cnt = 0;
  int cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_req) begin
      memreq_cnt <= memreq_cnt + 1;
      if (mem_we) begin
        for (int i = 0; i < 4; i++)
          if (mem_be[i]) mem_m[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end else begin
        mem_rdata <= mem_m[mem_addr];
      end
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        exok;
    logic        id;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: latency on first rvalid, stability while stalled, fields on handshake.
  int last_hs = -1;
  int hold_total = 0;
  initial begin
    logic        seen = 1'b0;
    logic        hold = 1'b0;
    logic [31:0] h_rdata;
    logic [2:0]  h_misc;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && rvalid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rvalid: got rvalid=1 expected no response (t=%0t)", $time);
        end else begin
          if (!seen) begin
            chk("latency_cycle", 32'(cyc), 32'(sb[0].cyc));
            seen = 1'b1;
          end
          if (rready) begin
            chk("rdata", rdata, sb[0].rdata);
            chk("err", 32'(err), 32'(sb[0].err));
            chk("exokay", 32'(exokay), 32'(sb[0].exok));
            chk("rid", 32'(rid), 32'(sb[0].id));
            void'(sb.pop_front());
            seen    = 1'b0;
            hold    = 1'b0;
            last_hs = cyc;
          end else begin
            if (hold) begin
              chk("stall_rdata_stable", rdata, h_rdata);
              chk("stall_rid_err_exok_stable", 32'({rid, err, exokay}), 32'(h_misc));
            end
            hold       = 1'b1;
            h_rdata    = rdata;
            h_misc     = {rid, err, exokay};
            hold_total = hold_total + 1;
          end
        end
      end
    end
  end

  // Drive a request at the current negedge; wait for grant; push expectation.
  task automatic issue(input logic [31:0] a, input logic w, input logic [3:0] b,
                       input logic [31:0] wd, input logic [5:0] at, input logic id,
                       input logic [31:0] er, input logic ee, input logic ex,
                       output logic first_gnt, output int gcyc);
    exp_t e;
    int   n = 0;
    req = 1'b1; addr = a; we = w; be = b; wdata = wd; atop = at; aid = id;
    #1;
    first_gnt = gnt;
    while (!gnt && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (!gnt) begin
      errors++;
      gcyc = -1;
      $display("FAIL grant_timeout: got gnt=0 expected gnt=1 within 20 cycles (addr 0x%08h)", a);
    end else begin
      gcyc    = cyc;
      e.rdata = er; e.err = ee; e.exok = ex; e.id = id; e.cyc = cyc + 2;
      sb.push_back(e);
    end
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic tx(input logic [31:0] a, input logic w, input logic [3:0] b,
                    input logic [31:0] wd, input logic [5:0] at, input logic id,
                    input logic [31:0] er, input logic ee, input logic ex);
    logic unused_fg;
    int   unused_gc;
    issue(a, w, b, wd, at, id, er, ee, ex, unused_fg, unused_gc);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic fg_a, fg_b;
    int   g_a, g_b, snap;

    req = 1'b1; addr = 32'h10; we = 1'b0; be = 4'hF; wdata = '0; atop = NONE; aid = 1'b1;
    rready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_rvalid", 32'(rvalid), 0);
    chk("reset_rdata", rdata, 0);
    chk("reset_rid", 32'(rid), 0);
    chk("reset_err", 32'(err), 0);
    chk("reset_exokay", 32'(exokay), 0);
    chk("reset_mem_req", 32'(mem_req), 0);
    chk("reset_mem_req_count", 32'(memreq_cnt), 0);
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Write then read back
    tx(32'h10, 1'b1, 4'hF, 32'hDEADBEEF, NONE, 1'b1, 32'h0, 1'b0, 1'b0);
    tx(32'h10, 1'b0, 4'hF, 32'h0, NONE, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0);
    drain();

    // AMOADD and signed AMOMIN
    tx(32'h10, 1'b1, 4'hF, 32'h5, NONE, 1'b0, 32'h0, 1'b0, 1'b0);
    tx(32'h10, 1'b1, 4'hF, 32'h3, ADD, 1'b1, 32'h5, 1'b0, 1'b0);
    drain();
    chk("mem4_after_add", mem_m[4], 32'h8);
    tx(32'h10, 1'b1, 4'hF, 32'hFFFFFFFF, MIN, 1'b0, 32'h8, 1'b0, 1'b0);
    drain();
    chk("mem4_after_min", mem_m[4], 32'hFFFFFFFF);

    // AMOMAXU with a competing request during AMO_WR
    issue(32'h10, 1'b1, 4'hF, 32'h1, MAXU, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, fg_a, g_a);
    issue(32'h10, 1'b0, 4'hF, 32'h0, NONE, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, fg_b, g_b);
    chk("gnt_low_in_amo_wr", 32'(fg_b), 0);
    chk("grant_in_amo_resp", 32'(g_b), 32'(g_a + 2));
    drain();
    chk("mem4_after_maxu", mem_m[4], 32'hFFFFFFFF);

    // Error responses never touch the SRAM
    snap = memreq_cnt;
    tx(NW * 4, 1'b0, 4'hF, 32'h0, NONE, 1'b1, 32'h0, 1'b1, 1'b0);
    tx(32'h10, 1'b1, 4'hF, 32'h0, 6'h3F, 1'b0, 32'h0, 1'b1, 1'b0);
    tx(32'h10, 1'b0, 4'hF, 32'h7, ADD, 1'b1, 32'h0, 1'b1, 1'b0);
    tx(32'h10, 1'b1, 4'h0, 32'h55, NONE, 1'b0, 32'h0, 1'b1, 1'b0);
    drain();
    chk("err_no_mem_req", 32'(memreq_cnt - snap), 0);
    chk("mem4_after_errors", mem_m[4], 32'hFFFFFFFF);

    // rready backpressure, then same-cycle grant on the handshake
    tx(32'h14, 1'b1, 4'hF, 32'hA5A50014, NONE, 1'b0, 32'h0, 1'b0, 1'b0);
    drain();
    rready = 1'b0;
    snap = hold_total;
    issue(32'h10, 1'b0, 4'hF, 32'h0, NONE, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, fg_a, g_a);
    fork
      issue(32'h14, 1'b0, 4'hF, 32'h0, NONE, 1'b0, 32'hA5A50014, 1'b0, 1'b0, fg_b, g_b);
      begin
        repeat (6) @(negedge clk);
        rready = 1'b1;
      end
    join
    chk("stall_cycles", 32'(hold_total - snap), 5);
    chk("grant_on_handshake", 32'(g_b), 32'(last_hs));
    drain();

`ifdef OBI_AMO_LRSC_EN
    tx(32'h20, 1'b1, 4'hF, 32'h12345678, NONE, 1'b0, 32'h0, 1'b0, 1'b0);
    tx(32'h20, 1'b1, 4'hF, 32'h0, LR, 1'b1, 32'h12345678, 1'b0, 1'b1);
    tx(32'h20, 1'b1, 4'hF, 32'hCAFEF00D, SC, 1'b0, 32'h0, 1'b0, 1'b1);
    drain();
    chk("mem8_after_sc_ok", mem_m[8], 32'hCAFEF00D);
    tx(32'h20, 1'b1, 4'hF, 32'h0, LR, 1'b1, 32'hCAFEF00D, 1'b0, 1'b1);
    tx(32'h20, 1'b1, 4'hF, 32'h11111111, NONE, 1'b0, 32'h0, 1'b0, 1'b0);
    tx(32'h20, 1'b1, 4'hF, 32'h22222222, SC, 1'b1, 32'h1, 1'b0, 1'b0);
    drain();
    chk("mem8_after_sc_fail", mem_m[8], 32'h11111111);
`else
    snap = memreq_cnt;
    tx(32'h20, 1'b1, 4'hF, 32'h0, LR, 1'b1, 32'h0, 1'b1, 1'b0);
    tx(32'h20, 1'b1, 4'hF, 32'h3, SC, 1'b0, 32'h0, 1'b1, 1'b0);
    drain();
    chk("lrsc_off_no_mem_req", 32'(memreq_cnt - snap), 0);
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
